i2c_txn_sched: RTL and testbench
================================

Name: i2c_txn_sched

Overview:
- Register-access transaction scheduler that shares one byte-level I2C master engine between NUM_REQ requesters, for example firmware or an init-ROM sequencer.
- Each request is a single register write or read: 7-bit address, 8-bit register, optional write byte.
- The block arbitrates round-robin, expands each request into START/WRITE/READ/STOP engine commands, and returns status and read data to the granted requester.
- It sits between requesters and the I2C engine that drives the scl/sda tristate pins.

Parameters:
NUM_REQ, 2, number of requesters (1..8).
TIMEOUT_CYC, 100000, max cycles from command handshake to eng_done_valid; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot 1-cycle grant; request fields are captured this cycle
req_rw  in  NUM_REQ  1=read, 0=write
req_addr  in  NUM_REQ*7  slave address, requester i at [7i+:7]
req_reg  in  NUM_REQ*8  register byte
req_wdata  in  NUM_REQ*8  write data (ignored for reads)
rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse
rsp_status  out  2  00 ok, 01 slave NACK, 10 timeout; valid with rsp_valid
rsp_rdata  out  8  read byte; 0 unless read with status 00
busy  out  1  high from grant through response
eng_cmd_valid  out  1  command valid to engine
eng_cmd_ready  in  1  engine accepts command
eng_cmd  out  3  i2c_cmd_e
eng_wdata  out  8  byte for CMD_WRITE
eng_rd_nack  out  1  for CMD_READ: 1 = master NACKs the byte
eng_done_valid  in  1  command completed
eng_done_nack  in  1  slave NACKed the WRITE
eng_done_rdata  in  8  byte returned by CMD_READ
eng_abort  out  1  1-cycle pulse on timeout

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = requester 0 highest priority. Reset is async and may hit mid-transaction: eng_cmd_valid drops immediately and no STOP is issued, because the engine is reset alongside.
- IDLE: if any req_valid, register winner g → GRANT. In GRANT, req_ready[g]=1 and fields are latched. busy rises in GRANT.
- Requesters hold req_valid and fields stable until req_ready. Lowering req_valid before the grant is legal; it is sampled in IDLE only.
- Round robin: search starts at (last_granted+1) mod NUM_REQ; the pointer updates on grant.
- Write sequence: START, WRITE {addr,0}, WRITE reg, WRITE wdata, STOP.
- Read sequence: START, WRITE {addr,0}, WRITE reg, START (repeated), WRITE {addr,1}, READ with eng_rd_nack=1, STOP.
- Each command step has two phases:
  - ISSUE: eng_cmd_valid=1 with eng_cmd/eng_wdata stable until eng_cmd_ready; first ISSUE is the cycle after GRANT.
  - WAIT: entered on handshake, valid deasserted, waits eng_done_valid. The next ISSUE begins the cycle after done.
- Back-to-back: zero idle cycles between done and next ISSUE.
- eng_done_valid outside WAIT is ignored.
- NACK: eng_done_nack=1 on any WRITE → skip the remaining steps, go to STOP, status 01.
- READ: latch eng_done_rdata on done.
- After STOP done → RESP. RESP drives rsp_valid[g] for 1 cycle with status/rdata, busy falls, then IDLE.
- A new request can win in the cycle after RESP.
- Timeout (TIMEOUT_CYC>0): counter clears on every cmd handshake and counts in WAIT.
- On reaching TIMEOUT_CYC: eng_abort pulses 1 cycle, no STOP, RESP with status 10.
- Done and terminal count in the same cycle: done wins.
- rsp_rdata and rsp_status hold their last values between pulses; consumers must only use them with rsp_valid.

Decomposition:
- Package i2c_pkg:
  - i2c_cmd_e: CMD_START=0, CMD_WRITE=1, CMD_READ=2, CMD_STOP=3.
  - i2c_status_e: ST_OK=0, ST_NACK=1, ST_TIMEOUT=2.
  - Scheduler state enum: IDLE, GRANT, START, ADDR_W, REG, DATA, RSTART, ADDR_R, READ, STOP, RESP.
- Sub-module i2c_rr_arb (parameter N): inputs req[N] and advance; output grant one-hot and rotating pointer.

Test Plan:
1. Req0 write, addr 7'h55, reg 8'h12, wdata 8'hA5, engine always acks → cmds START, WRITE 8'hAA, WRITE 8'h12, WRITE 8'hA5, STOP; rsp_valid[0], status 00.
2. Req1 read, addr 7'h58, reg 8'h00, engine returns 8'h3C → START, WRITE 8'hB0, WRITE 8'h00, START, WRITE 8'hB1, READ rd_nack=1, STOP; rsp_rdata 8'h3C, status 00.
3. Engine NACKs first WRITE of a read → next cmd is STOP; status 01, rdata 8'h00.
4. req_valid[0] and req_valid[1] held high for 4 transactions → grant order 0,1,0,1; eng_cmd_ready held low 5 cycles → cmd and wdata stable throughout.
5. TIMEOUT_CYC=50, engine never returns done after WRITE reg → eng_abort exactly 50 cycles after handshake, status 10, next request starts with START.
6. Assert rst during REG WAIT → outputs 0 asynchronously; after release, both requesting → requester 0 granted first.

Source files
------------

// File: rtl/i2c_txn_sched_pkg.sv
// rtl/i2c_txn_sched_pkg.sv - shared types for the I2C transaction scheduler
package i2c_pkg;

   typedef enum logic [2:0] {
      CMD_START = 3'd0,
      CMD_WRITE = 3'd1,
      CMD_READ  = 3'd2,
      CMD_STOP  = 3'd3
   } i2c_cmd_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_NACK    = 2'd1,
      ST_TIMEOUT = 2'd2
   } i2c_status_e;

   typedef enum logic [3:0] {
      IDLE, GRANT, START, ADDR_W, REG, DATA, RSTART, ADDR_R, READ, STOP, RESP
   } sched_state_e;

   // Engine command issued by each command step of the scheduler
   function automatic i2c_cmd_e state_cmd(input sched_state_e s);
      case (s)
         START, RSTART:            return CMD_START;
         ADDR_W, REG, DATA, ADDR_R: return CMD_WRITE;
         READ:                     return CMD_READ;
         STOP:                     return CMD_STOP;
         default:                  return CMD_START;
      endcase
   endfunction

endpackage

// File: rtl/i2c_txn_sched_if.sv
// rtl/i2c_txn_sched_if.sv - command/done handshake between scheduler and byte engine
interface i2c_txn_sched_if;
   import i2c_pkg::*;

   logic       eng_cmd_valid;
   logic       eng_cmd_ready;
   i2c_cmd_e   eng_cmd;
   logic [7:0] eng_wdata;
   logic       eng_rd_nack;
   logic       eng_done_valid;
   logic       eng_done_nack;
   logic [7:0] eng_done_rdata;
   logic       eng_abort;

   modport master (
      output eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack, eng_abort,
      input  eng_cmd_ready, eng_done_valid, eng_done_nack, eng_done_rdata
   );

   modport slave (
      input  eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack, eng_abort,
      output eng_cmd_ready, eng_done_valid, eng_done_nack, eng_done_rdata
   );

endinterface

// File: rtl/i2c_txn_sched_arb.sv
// rtl/i2c_txn_sched_arb.sv - round-robin arbiter with rotating priority pointer
module i2c_rr_arb #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] ptr
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;
   int            j;

   // First active request at or after the pointer wins; pointer moves past it
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_q) + i) % N;
         if (req[j] && !found) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            if (advance) ptr_d = IW'((j + 1) % N);
         end
      end
   end

   // Pointer register; requester 0 has top priority out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/i2c_txn_sched.sv
// rtl/i2c_txn_sched.sv - shares one I2C byte engine between register-access requesters
module i2c_txn_sched
   import i2c_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ-1:0]   req_rw,
   input  logic [NUM_REQ*7-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0] req_reg,
   input  logic [NUM_REQ*8-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [1:0]           rsp_status,
   output logic [7:0]           rsp_rdata,
   output logic                 busy,
   i2c_txn_sched_if.master      eng
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_e state_q, state_d;
   logic         wait_q, wait_d;
   logic [31:0]  cnt_q, cnt_d;
   logic         rw_q, rw_d;
   logic [6:0]   addr_q, addr_d;
   logic [7:0]   reg_q, reg_d;
   logic [7:0]   wdata_q, wdata_d;
   i2c_status_e  st_q, st_d;
   logic [7:0]   rd_q, rd_d;
   logic [1:0]   rsp_status_q, rsp_status_d;
   logic [7:0]   rsp_rdata_q, rsp_rdata_d;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      g_idx;

   i2c_rr_arb #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (state_q == IDLE),
      .grant   (grant),
      .ptr     (ptr)
   );

   // The pointer only moves on a grant, so the owner is always the slot just behind it
   assign g_idx = (ptr == '0) ? IW'(NUM_REQ - 1) : ptr - 1'b1;

   // Transaction sequencing, engine handshake and response capture
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      cnt_d        = cnt_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      reg_d        = reg_q;
      wdata_d      = wdata_q;
      st_d         = st_q;
      rd_d         = rd_q;
      rsp_status_d = rsp_status_q;
      rsp_rdata_d  = rsp_rdata_q;
      req_ready    = '0;
      rsp_valid    = '0;
      busy         = (state_q != IDLE);

      eng.eng_cmd_valid = 1'b0;
      eng.eng_abort     = 1'b0;
      eng.eng_cmd       = state_cmd(state_q);
      eng.eng_rd_nack   = (state_q == READ);
      case (state_q)
         ADDR_W:  eng.eng_wdata = {addr_q, 1'b0};
         REG:     eng.eng_wdata = reg_q;
         DATA:    eng.eng_wdata = wdata_q;
         ADDR_R:  eng.eng_wdata = {addr_q, 1'b1};
         default: eng.eng_wdata = 8'h00;
      endcase

      case (state_q)
         IDLE: begin
            if (|grant) state_d = GRANT;
         end
         GRANT: begin
            req_ready[g_idx] = 1'b1;
            rw_d    = req_rw[g_idx];
            addr_d  = req_addr[7*g_idx +: 7];
            reg_d   = req_reg[8*g_idx +: 8];
            wdata_d = req_wdata[8*g_idx +: 8];
            st_d    = ST_OK;
            rd_d    = 8'h00;
            wait_d  = 1'b0;
            state_d = START;
         end
         RESP: begin
            rsp_valid[g_idx] = 1'b1;
            state_d = IDLE;
         end
         default: begin
            if (!wait_q) begin
               eng.eng_cmd_valid = 1'b1;
               if (eng.eng_cmd_ready) begin
                  wait_d = 1'b1;
                  cnt_d  = 32'd0;
               end
            end else if (eng.eng_done_valid) begin
               wait_d = 1'b0;
               if (state_q == READ) rd_d = eng.eng_done_rdata;
               if (state_cmd(state_q) == CMD_WRITE && eng.eng_done_nack) begin
                  st_d    = ST_NACK;
                  state_d = STOP;
               end else begin
                  case (state_q)
                     START:   state_d = ADDR_W;
                     ADDR_W:  state_d = REG;
                     REG:     state_d = rw_q ? RSTART : DATA;
                     RSTART:  state_d = ADDR_R;
                     ADDR_R:  state_d = READ;
                     STOP:    state_d = RESP;
                     default: state_d = STOP;
                  endcase
               end
            end else if (TIMEOUT_CYC > 0 && cnt_q == 32'(TIMEOUT_CYC - 1)) begin
               // The engine is abandoned mid-byte, so no STOP is attempted
               eng.eng_abort = 1'b1;
               st_d    = ST_TIMEOUT;
               wait_d  = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
      endcase

      if (state_d == RESP && state_q != RESP) begin
         rsp_status_d = st_d;
         rsp_rdata_d  = (rw_q && st_d == ST_OK) ? rd_d : 8'h00;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_q       <= 1'b0;
         cnt_q        <= 32'd0;
         rw_q         <= 1'b0;
         addr_q       <= 7'h00;
         reg_q        <= 8'h00;
         wdata_q      <= 8'h00;
         st_q         <= ST_OK;
         rd_q         <= 8'h00;
         rsp_status_q <= 2'b00;
         rsp_rdata_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         cnt_q        <= cnt_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         reg_q        <= reg_d;
         wdata_q      <= wdata_d;
         st_q         <= st_d;
         rd_q         <= rd_d;
         rsp_status_q <= rsp_status_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   assign rsp_status = rsp_status_q;
   assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_txn_sched.sv
// tb/tb_i2c_txn_sched.sv - scoreboard bench for the I2C transaction scheduler
module tb_i2c_txn_sched;
   import i2c_pkg::*;

   localparam int NR  = 2;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_rw    = '0;
   logic [NR*7-1:0] req_addr  = '0;
   logic [NR*8-1:0] req_reg   = '0;
   logic [NR*8-1:0] req_wdata = '0;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   rsp_valid;
   logic [1:0]      rsp_status;
   logic [7:0]      rsp_rdata;
   logic            busy;

   i2c_txn_sched_if eif ();

   i2c_txn_sched #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_reg    (req_reg),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_status (rsp_status),
      .rsp_rdata  (rsp_rdata),
      .busy       (busy),
      .eng        (eif.master)
   );

   typedef struct packed {
      logic [2:0] cmd;
      logic [7:0] wd;
      logic       rdn;
   } cmd_t;

   typedef struct {
      int         idx;
      logic [1:0] st;
      logic [7:0] rd;
   } rsp_t;

   cmd_t cq[$];
   rsp_t rq[$];
   int   gq[$];

   int n_chk = 0, n_pass = 0, n_fail = 0, n_abort = 0;
   int ready_delay = 0, nack_at = -1, hang_at = -1;
   bit stray = 1'b0;
   logic [7:0] rd_byte = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [2:0] c, input logic [7:0] w, input logic n);
      cmd_t r;
      r.cmd = c;
      r.wd  = w;
      r.rdn = n;
      return r;
   endfunction

   task automatic set_req(input int i, input bit rw, input logic [6:0] a, input logic [7:0] r, input logic [7:0] w);
      req_rw[i]          = rw;
      req_addr[7*i +: 7] = a;
      req_reg[8*i +: 8]  = r;
      req_wdata[8*i +: 8] = w;
      req_valid[i]       = 1'b1;
   endtask

   // Expected grant, engine command stream and response for one request
   task automatic expect_txn(input int i, input bit rw, input logic [6:0] a, input logic [7:0] r,
                             input logic [7:0] w, input int nk, input int hg, input logic [7:0] rd);
      cmd_t seq[$];
      rsp_t e;
      seq.push_back(mk(CMD_START, 8'h00, 1'b0));
      seq.push_back(mk(CMD_WRITE, {a, 1'b0}, 1'b0));
      seq.push_back(mk(CMD_WRITE, r, 1'b0));
      if (rw) begin
         seq.push_back(mk(CMD_START, 8'h00, 1'b0));
         seq.push_back(mk(CMD_WRITE, {a, 1'b1}, 1'b0));
         seq.push_back(mk(CMD_READ, 8'h00, 1'b1));
      end else begin
         seq.push_back(mk(CMD_WRITE, w, 1'b0));
      end
      seq.push_back(mk(CMD_STOP, 8'h00, 1'b0));
      for (int k = 0; k < seq.size(); k++) begin
         cq.push_back(seq[k]);
         if (k == nk) begin
            cq.push_back(mk(CMD_STOP, 8'h00, 1'b0));
            break;
         end
         if (k == hg) break;
      end
      e.idx = i;
      e.st  = (nk >= 0) ? 2'd1 : (hg >= 0) ? 2'd2 : 2'd0;
      e.rd  = (nk < 0 && hg < 0 && rw) ? rd : 8'h00;
      gq.push_back(i);
      rq.push_back(e);
   endtask

   // Engine model and output checker; returns after n_rsp responses or stop_hs handshakes
   task automatic run(input int n_rsp, input int stop_hs, input bit hold);
      int got = 0, hs = 0, hs_cyc = 0, cmd_idx = 0, wl;
      bit pend = 1'b0, waiting = 1'b0, prev_rsp = 1'b0;
      wl = ready_delay;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         eif.eng_cmd_ready  = 1'b0;
         eif.eng_done_valid = 1'b0;
         eif.eng_done_nack  = 1'b0;
         eif.eng_done_rdata = 8'h00;
         if (prev_rsp) chk("idle_after_rsp", {busy, rsp_valid}, 32'd0);
         prev_rsp = 1'b0;
         if (req_ready != '0) begin
            if (gq.size() == 0) chk("grant_unexpected", req_ready, 32'd0);
            else begin
               int g = gq.pop_front();
               chk("grant", req_ready, 32'd1 << g);
               if (!hold) req_valid[g] = 1'b0;
            end
            cmd_idx = 0;
         end
         if (eif.eng_abort) begin
            n_abort++;
            chk("abort_delay", c - hs_cyc, TMO);
            pend = 1'b0;
         end
         if (pend) begin
            if (cmd_idx - 1 != hang_at) begin
               eif.eng_done_valid = 1'b1;
               eif.eng_done_nack  = (cmd_idx - 1 == nack_at);
               eif.eng_done_rdata = rd_byte;
               pend = 1'b0;
            end
         end else if (eif.eng_cmd_valid) begin
            if (cq.size() == 0) chk("cmd_unexpected", eif.eng_cmd_valid, 32'd0);
            else begin
               chk("cmd", eif.eng_cmd, cq[0].cmd);
               if (cq[0].cmd == CMD_WRITE) chk("wdata", eif.eng_wdata, cq[0].wd);
               if (cq[0].cmd == CMD_READ)  chk("rd_nack", eif.eng_rd_nack, cq[0].rdn);
               if (wl > 0) begin
                  wl--;
                  waiting = 1'b1;
                  if (stray) begin
                     eif.eng_done_valid = 1'b1;
                     eif.eng_done_nack  = 1'b1;
                  end
               end else begin
                  eif.eng_cmd_ready = 1'b1;
                  void'(cq.pop_front());
                  pend    = 1'b1;
                  waiting = 1'b0;
                  cmd_idx++;
                  hs++;
                  hs_cyc = c;
                  wl = ready_delay;
               end
            end
         end else if (waiting) begin
            chk("valid_held", eif.eng_cmd_valid, 32'd1);
         end
         if (rsp_valid != '0) begin
            if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 32'd0);
            else begin
               rsp_t e = rq.pop_front();
               chk("rsp_valid", rsp_valid, 32'd1 << e.idx);
               chk("rsp_status", rsp_status, e.st);
               chk("rsp_rdata", rsp_rdata, e.rd);
            end
            got++;
            prev_rsp = 1'b1;
         end
         if (stop_hs > 0 && hs == stop_hs) return;
         if (got == n_rsp) return;
      end
      chk("run_budget", got, n_rsp);
   endtask

   initial begin
      eif.eng_cmd_ready  = 1'b0;
      eif.eng_done_valid = 1'b0;
      eif.eng_done_nack  = 1'b0;
      eif.eng_done_rdata = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {req_ready, rsp_valid, busy, eif.eng_cmd_valid, eif.eng_abort,
                            eif.eng_rd_nack, eif.eng_cmd, eif.eng_wdata, rsp_status, rsp_rdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Plain write from requester 0
      set_req(0, 1'b0, 7'h55, 8'h12, 8'hA5);
      expect_txn(0, 1'b0, 7'h55, 8'h12, 8'hA5, -1, -1, 8'h00);
      run(1, 0, 1'b0);

      // Read from requester 1
      rd_byte = 8'h3C;
      set_req(1, 1'b1, 7'h58, 8'h00, 8'h00);
      expect_txn(1, 1'b1, 7'h58, 8'h00, 8'h00, -1, -1, 8'h3C);
      run(1, 0, 1'b0);

      // Address NACK on a read cuts straight to STOP
      nack_at = 1;
      rd_byte = 8'hEE;
      set_req(1, 1'b1, 7'h58, 8'h07, 8'h00);
      expect_txn(1, 1'b1, 7'h58, 8'h07, 8'h00, 1, -1, 8'hEE);
      run(1, 0, 1'b0);
      nack_at = -1;

      // Both requesters held: alternating grants, slow engine, stray dones while issuing
      ready_delay = 5;
      stray = 1'b1;
      set_req(0, 1'b0, 7'h10, 8'h01, 8'h11);
      set_req(1, 1'b0, 7'h20, 8'h02, 8'h22);
      expect_txn(0, 1'b0, 7'h10, 8'h01, 8'h11, -1, -1, 8'h00);
      expect_txn(1, 1'b0, 7'h20, 8'h02, 8'h22, -1, -1, 8'h00);
      expect_txn(0, 1'b0, 7'h10, 8'h01, 8'h11, -1, -1, 8'h00);
      expect_txn(1, 1'b0, 7'h20, 8'h02, 8'h22, -1, -1, 8'h00);
      run(4, 0, 1'b1);
      req_valid = '0;
      ready_delay = 0;
      stray = 1'b0;

      // Engine hangs after the register byte handshake
      hang_at = 2;
      set_req(0, 1'b0, 7'h33, 8'h44, 8'h55);
      expect_txn(0, 1'b0, 7'h33, 8'h44, 8'h55, -1, 2, 8'h00);
      run(1, 0, 1'b0);
      hang_at = -1;
      chk("abort_count", n_abort, 32'd1);

      // Next request after the timeout starts cleanly
      rd_byte = 8'h5A;
      set_req(1, 1'b1, 7'h21, 8'h09, 8'h00);
      expect_txn(1, 1'b1, 7'h21, 8'h09, 8'h00, -1, -1, 8'h5A);
      run(1, 0, 1'b0);

      // Reset while waiting on the register byte
      set_req(0, 1'b0, 7'h0F, 8'h10, 8'h20);
      expect_txn(0, 1'b0, 7'h0F, 8'h10, 8'h20, -1, -1, 8'h00);
      run(1, 3, 1'b0);
      @(negedge clk);
      eif.eng_cmd_ready = 1'b0;
      @(negedge clk);
      chk("busy_before_rst", busy, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outputs", {req_ready, rsp_valid, busy, eif.eng_cmd_valid, eif.eng_abort,
                                rsp_status, rsp_rdata}, 32'd0);
      cq.delete();
      rq.delete();
      gq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Both requesting after reset: requester 0 first
      set_req(0, 1'b0, 7'h11, 8'h22, 8'h33);
      set_req(1, 1'b0, 7'h44, 8'h55, 8'h66);
      expect_txn(0, 1'b0, 7'h11, 8'h22, 8'h33, -1, -1, 8'h00);
      expect_txn(1, 1'b0, 7'h44, 8'h55, 8'h66, -1, -1, 8'h00);
      run(2, 0, 1'b0);
      chk("abort_total", n_abort, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
